cpu_fetch_sequencer: RTL

- Front end of the CPU.
- Fetches 16-bit instructions from instruction memory using a request/ready handshake.
- Holds the instruction register (IR) that feeds the instruction decoder.
- Consumes the decoder's PS (PC select) and NS (next state) control outputs to update the program counter and the 1-bit execute-state signal returned to the decoder.

---
 rtl/cpu_fetch_sequencer_pkg.sv | 21 ++
 rtl/cpu_fetch_sequencer_if.sv | 26 ++
 rtl/cpu_fetch_sequencer_pc_unit.sv | 42 ++++
 rtl/cpu_fetch_sequencer.sv | 83 ++++++++
 4 files changed

// File: rtl/cpu_fetch_sequencer_pkg.sv
// Shared CPU front-end definitions: instruction width, PC-select codes,
// sequencer state encodings and the halt opcode.
package cpu_fetch_sequencer_pkg;

    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] CPU_HALT_OPC = 16'hFFFF;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_BR   = 2'b10,
        PS_JMP  = 2'b11
    } ps_e;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EX0   = 2'd1;
    localparam logic [1:0] ST_EX1   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/cpu_fetch_sequencer_if.sv
// Instruction-memory request/ready fetch port.
interface cpu_fetch_sequencer_if #(
    parameter int PC_W = 16
);
    import cpu_fetch_sequencer_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rdy;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_data
    );

endinterface

// File: rtl/cpu_fetch_sequencer_pc_unit.sv
// Program counter register with hold/increment/relative-branch/jump next-PC mux.
module cpu_pc_unit
    import cpu_fetch_sequencer_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [1:0]         ps,
    input  logic [7:0]         br_off,
    input  logic [INSTR_W-1:0] ra_data,
    output logic [PC_W-1:0]    pc
);

    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] br_ext;

    assign br_ext = {{(PC_W-8){br_off[7]}}, br_off};

    // All arithmetic is modulo 2^PC_W; carries out are dropped on purpose.
    always_comb begin
        pc_next = pc;
        case (ps_e'(ps))
            PS_HOLD: pc_next = pc;
            PS_INC:  pc_next = pc + {{(PC_W-1){1'b0}}, 1'b1};
            PS_BR:   pc_next = pc + br_ext;
            PS_JMP:  pc_next = ra_data[PC_W-1:0];
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// CPU front end: fetches instructions into IR and sequences FETCH/EX0/EX1/HALT.
//   state    | meaning
//   ST_FETCH | imem_req held with imem_addr=pc until imem_rdy loads ir
//   ST_EX0   | first execute cycle, pc updated per ps
//   ST_EX1   | second execute cycle (ns=1 in EX0), pc updated per ps
//   ST_HALT  | halt opcode or illegal ns=1 in EX1; only rst leaves
module cpu_fetch_sequencer
    import cpu_fetch_sequencer_pkg::*;
#(
    parameter int                 PC_W     = 16,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] HALT_OPC = CPU_HALT_OPC
) (
    input  logic               clk,
    input  logic               rst,
    cpu_fetch_sequencer_if.master imem,
    input  logic [1:0]         ps,
    input  logic               ns,
    input  logic [INSTR_W-1:0] ra_data,
    output logic [INSTR_W-1:0] ir,
    output logic               state,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               illegal
);

    logic [1:0] st;
    logic [1:0] st_next;
    logic       fetch_done;
    logic       pc_load;

    assign fetch_done = (st == ST_FETCH) && imem.imem_rdy;
    assign pc_load    = (st == ST_EX0) || (st == ST_EX1);

    always_comb begin
        st_next = st;
        case (st)
            ST_FETCH: if (imem.imem_rdy)
                          st_next = (imem.imem_data == HALT_OPC) ? ST_HALT : ST_EX0;
            ST_EX0:   st_next = ns ? ST_EX1 : ST_FETCH;
            ST_EX1:   st_next = ns ? ST_HALT : ST_FETCH;
            ST_HALT:  st_next = ST_HALT;
            default:  st_next = ST_FETCH;
        endcase
    end

    // state is registered from st_next so it is valid in the first EX1 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_FETCH;
            state   <= 1'b0;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            st    <= st_next;
            state <= (st_next == ST_EX1);
            if (fetch_done) begin
                ir <= imem.imem_data;
            end
            if ((st == ST_EX1) && ns) begin
                illegal <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = (st == ST_FETCH) && !rst;
    assign imem.imem_addr = pc;
    assign halted         = (st == ST_HALT);

    cpu_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .ps      (ps),
        .br_off  (ir[7:0]),
        .ra_data (ra_data),
        .pc      (pc)
    );

endmodule
